// File: rtl/zigbee_pad_pkg.sv
// Shared definitions for the Zigbee pad bridge: pad modes, pad bus bit map
// and default sizing.
package zigbee_pad_pkg;

  typedef enum logic [1:0] {
    PAD_IDLE   = 2'b00,
    PAD_WRITE  = 2'b01,
    PAD_READ   = 2'b10,
    PAD_STATUS = 2'b11
  } pad_mode_e;

  localparam int PAD_DEFAULT_DEPTH       = 16;
  localparam int PAD_DEFAULT_SYNC_STAGES = 2;
  localparam int PAD_FIFO_WIDTH          = 9;

  // Pad input bus; bits at or above MUX_I_USED_W are reserved.
  localparam int MUX_I_W       = 22;
  localparam int MUX_I_USED_W  = 11;
  localparam int MI_DATA_LSB   = 0;
  localparam int MI_LAST       = 8;
  localparam int MI_CLEAR      = 9;
  localparam int MI_STROBE     = 10;

  // Pad output bus.
  localparam int MUX_O_W       = 18;
  localparam int MO_RX_DATA_LSB = 0;
  localparam int MO_RX_LAST    = 8;
  localparam int MO_RX_NEMPTY  = 9;
  localparam int MO_ACK        = 10;
  localparam int MO_TX_FULL    = 11;
  localparam int MO_TXCNT_LSB  = 0;
  localparam int MO_RXCNT_LSB  = 6;
  localparam int MO_OVF        = 12;
  localparam int MO_UNF        = 13;
  localparam int CNT_FIELD_W   = 6;

endpackage

// File: rtl/zigbee_pad_fifo.sv
// Synchronous FIFO with occupancy count. A push into a full FIFO only lands
// when a pop frees a slot in the same cycle; a pop from an empty FIFO is ignored.
module zigbee_pad_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; count saturates by construction.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/zigbee_pad_bridge.sv
// Bridges a slow, multiplexed pad interface to a core-side byte stream pair.
// Pad strobes are edge (toggle) coded and act on the synchronized mode.
module zigbee_pad_bridge
  import zigbee_pad_pkg::*;
#(
  parameter int DEPTH       = PAD_DEFAULT_DEPTH,
  parameter int SYNC_STAGES = PAD_DEFAULT_SYNC_STAGES
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [1:0]         sel_i,
  input  logic [MUX_I_W-1:0] mux_i,
  output logic [MUX_O_W-1:0] mux_o,
  output logic [7:0]         tx_data_o,
  output logic               tx_last_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_last_i,
  input  logic               rx_valid_i,
  output logic               rx_ready_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = 2 + MUX_I_USED_W;

  logic [SW-1:0]               sync_q [SYNC_STAGES];
  logic [SW-1:0]               sync_out;
  logic [MUX_I_USED_W-1:0]     pad_in;
  pad_mode_e                   mode;
  logic                        strobe_prev;
  logic                        strobe_evt;
  logic                        wr_strobe;
  logic                        rd_strobe;
  logic                        st_strobe;
  logic                        ack;
  logic                        ovf_sticky;
  logic                        unf_sticky;
  logic                        ovf_set;
  logic                        unf_set;
  logic                        sticky_clr;
  logic                        alive;
  logic                        tx_pop;
  logic                        rx_push;
  logic                        tx_full;
  logic                        tx_empty;
  logic                        rx_full;
  logic                        rx_empty;
  logic [CW-1:0]               tx_count;
  logic [CW-1:0]               rx_count;
  logic [PAD_FIFO_WIDTH-1:0]   tx_head;
  logic [PAD_FIFO_WIDTH-1:0]   rx_head;
  logic [MUX_O_W-1:0]          mux_next;
  logic                        unused_pad_bits;

  assign unused_pad_bits = ^mux_i[MUX_I_W-1:MUX_I_USED_W];

  // Plain flop chain bringing the asynchronous pad mode and bus into clk_i.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= {sel_i, mux_i[MUX_I_USED_W-1:0]};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_out   = sync_q[SYNC_STAGES-1];
  assign mode       = pad_mode_e'(sync_out[SW-1 -: 2]);
  assign pad_in     = sync_out[MUX_I_USED_W-1:0];
  assign strobe_evt = pad_in[MI_STROBE] ^ strobe_prev;
  assign wr_strobe  = strobe_evt && (mode == PAD_WRITE);
  assign rd_strobe  = strobe_evt && (mode == PAD_READ);
  assign st_strobe  = strobe_evt && (mode == PAD_STATUS);

  assign tx_valid_o = !tx_empty;
  assign tx_data_o  = tx_head[7:0];
  assign tx_last_o  = tx_head[8];
  assign tx_pop     = tx_valid_o && tx_ready_i;
  assign rx_ready_o = alive && !rx_full;
  assign rx_push    = rx_valid_i && rx_ready_o;

  assign ovf_set    = wr_strobe && tx_full && !tx_pop;
  assign unf_set    = rd_strobe && rx_empty;
  assign sticky_clr = st_strobe && pad_in[MI_CLEAR];

  zigbee_pad_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAD_FIFO_WIDTH)
  ) u_tx_fifo (
    .clk   (clk_i),
    .reset (reset_i),
    .push  (wr_strobe),
    .wdata ({pad_in[MI_LAST], pad_in[MI_DATA_LSB +: 8]}),
    .pop   (tx_pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  zigbee_pad_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAD_FIFO_WIDTH)
  ) u_rx_fifo (
    .clk   (clk_i),
    .reset (reset_i),
    .push  (rx_push),
    .wdata ({rx_last_i, rx_data_i}),
    .pop   (rd_strobe),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // Strobe edge memory, ack toggle, sticky errors (set beats clear) and post-reset guard.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      strobe_prev <= 1'b0;
      ack         <= 1'b0;
      ovf_sticky  <= 1'b0;
      unf_sticky  <= 1'b0;
      alive       <= 1'b0;
    end else begin
      strobe_prev <= pad_in[MI_STROBE];
      alive       <= 1'b1;
      if (strobe_evt && (mode != PAD_IDLE)) begin
        ack <= ~ack;
      end
      if (ovf_set) begin
        ovf_sticky <= 1'b1;
      end else if (sticky_clr) begin
        ovf_sticky <= 1'b0;
      end
      if (unf_set) begin
        unf_sticky <= 1'b1;
      end else if (sticky_clr) begin
        unf_sticky <= 1'b0;
      end
    end
  end

  // Assemble the pad output view for the synchronized mode.
  always_comb begin
    mux_next = '0;
    case (mode)
      PAD_WRITE: begin
        mux_next[MO_TX_FULL] = tx_full;
        mux_next[MO_ACK]     = ack;
      end
      PAD_READ: begin
        if (!rx_empty) begin
          mux_next[MO_RX_DATA_LSB +: 8] = rx_head[7:0];
          mux_next[MO_RX_LAST]          = rx_head[8];
          mux_next[MO_RX_NEMPTY]        = 1'b1;
        end
        mux_next[MO_ACK] = ack;
      end
      PAD_STATUS: begin
        mux_next[MO_TXCNT_LSB +: CNT_FIELD_W] = CNT_FIELD_W'(tx_count);
        mux_next[MO_RXCNT_LSB +: CNT_FIELD_W] = CNT_FIELD_W'(rx_count);
        mux_next[MO_OVF]                      = ovf_sticky;
        mux_next[MO_UNF]                      = unf_sticky;
        mux_next[MO_ACK]                      = ack;
      end
      default: ;
    endcase
  end

  // Register the pad output so the pads see glitch-free levels.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mux_o <= '0;
    end else begin
      mux_o <= mux_next;
    end
  end

endmodule

// File: tb/tb_zigbee_pad_bridge.sv
// Self-checking bench for zigbee_pad_bridge: a directed vector table, hand
// sequences for the multi-cycle corners, then randomized traffic against a
// queue-based reference model.
module tb_zigbee_pad_bridge;
  import zigbee_pad_pkg::*;

  localparam int DEPTH = 16;
  localparam int SS    = 2;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [1:0]  sel_i;
  logic [21:0] mux_i;
  logic [17:0] mux_o;
  logic [7:0]  tx_data_o;
  logic        tx_last_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  rx_data_i;
  logic        rx_last_i;
  logic        rx_valid_i;
  logic        rx_ready_o;

  int vectors    = 0;
  int miscompares = 0;

  logic       strobe_level;
  logic [8:0] tx_q[$];
  logic [8:0] rx_q[$];
  logic [8:0] drained[$];
  logic       m_ack, m_ovf, m_unf;

  typedef struct {
    pad_mode_e   mode;
    logic [7:0]  data;
    logic        last;
    logic        clear;
    logic [17:0] exp_mux;
  } vec_t;

  vec_t vecs [7];

  zigbee_pad_bridge #(.DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .sel_i      (sel_i),
    .mux_i      (mux_i),
    .mux_o      (mux_o),
    .tx_data_o  (tx_data_o),
    .tx_last_o  (tx_last_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .rx_data_i  (rx_data_i),
    .rx_last_i  (rx_last_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] expMux(input pad_mode_e m);
    logic [17:0] r;
    r = '0;
    case (m)
      PAD_WRITE: begin
        r[11] = (tx_q.size() == DEPTH);
        r[10] = m_ack;
      end
      PAD_READ: begin
        if (rx_q.size() > 0) begin
          r[8:0] = rx_q[0];
          r[9]   = 1'b1;
        end
        r[10] = m_ack;
      end
      PAD_STATUS: begin
        r[5:0]  = 6'(tx_q.size());
        r[11:6] = 6'(rx_q.size());
        r[12]   = m_ovf;
        r[13]   = m_unf;
        r[10]   = m_ack;
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic doReset();
    reset_i      = 1'b1;
    sel_i        = 2'b00;
    mux_i        = '0;
    strobe_level = 1'b0;
    tx_ready_i   = 1'b0;
    rx_valid_i   = 1'b0;
    rx_data_i    = '0;
    rx_last_i    = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_mux", 32'(mux_o), 32'h0);
    checkOutput("rst_tx_valid", 32'(tx_valid_o), 32'h0);
    checkOutput("rst_rx_ready", 32'(rx_ready_o), 32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    checkOutput("post_rst_mux", 32'(mux_o), 32'h0);
    checkOutput("post_rst_tx_valid", 32'(tx_valid_o), 32'h0);
    checkOutput("post_rst_rx_ready", 32'(rx_ready_o), 32'h0);
    @(negedge clk_i);
    checkOutput("rx_ready_up", 32'(rx_ready_o), 32'h1);
    tx_q.delete();
    rx_q.delete();
    m_ack = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One pad strobe; checks ack is still old one edge early and new at the spec'd edge.
  task automatic applyStimulus(input pad_mode_e mode, input logic [7:0] data, input logic last,
                               input logic clear, input logic pop_at_action);
    logic did_pop;
    did_pop      = 1'b0;
    strobe_level = ~strobe_level;
    sel_i        = mode;
    mux_i        = '0;
    mux_i[21:11] = 11'($urandom);
    mux_i[7:0]   = data;
    mux_i[8]     = last;
    mux_i[9]     = clear;
    mux_i[10]    = strobe_level;
    repeat (SS) @(negedge clk_i);
    if (pop_at_action) begin
      tx_ready_i = 1'b1;
      checkOutput("pop_valid", 32'(tx_valid_o), 32'(tx_q.size() > 0));
      if (tx_q.size() > 0) begin
        checkOutput("pop_byte", 32'({tx_last_o, tx_data_o}), 32'(tx_q[0]));
        did_pop = 1'b1;
      end
    end
    @(negedge clk_i);
    tx_ready_i = 1'b0;
    checkOutput("ack_early", 32'(mux_o), 32'(expMux(mode)));
    if (did_pop) begin
      drained.push_back(tx_q.pop_front());
    end
    case (mode)
      PAD_WRITE: begin
        if (tx_q.size() < DEPTH) tx_q.push_back({last, data});
        else m_ovf = 1'b1;
        m_ack = ~m_ack;
      end
      PAD_READ: begin
        if (rx_q.size() > 0) void'(rx_q.pop_front());
        else m_unf = 1'b1;
        m_ack = ~m_ack;
      end
      PAD_STATUS: begin
        if (clear) begin
          m_ovf = 1'b0;
          m_unf = 1'b0;
        end
        m_ack = ~m_ack;
      end
      default: ;
    endcase
    @(negedge clk_i);
    checkOutput("ack_on_time", 32'(mux_o), 32'(expMux(mode)));
  endtask

  task automatic setMode(input pad_mode_e mode);
    sel_i = mode;
    repeat (SS + 1) @(negedge clk_i);
    checkOutput("mode_view", 32'(mux_o), 32'(expMux(mode)));
  endtask

  task automatic drainTx(input int n);
    for (int i = 0; i < n; i++) begin
      tx_ready_i = 1'b1;
      checkOutput("tx_valid", 32'(tx_valid_o), 32'(tx_q.size() > 0));
      if (tx_q.size() > 0) begin
        checkOutput("tx_byte", 32'({tx_last_o, tx_data_o}), 32'(tx_q[0]));
        drained.push_back(tx_q.pop_front());
      end
      @(negedge clk_i);
    end
    tx_ready_i = 1'b0;
  endtask

  task automatic pushRx(input logic [7:0] data, input logic last);
    logic exp_ready;
    exp_ready  = (rx_q.size() < DEPTH);
    rx_valid_i = 1'b1;
    rx_data_i  = data;
    rx_last_i  = last;
    checkOutput("rx_ready", 32'(rx_ready_o), 32'(exp_ready));
    if (exp_ready) rx_q.push_back({last, data});
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{PAD_WRITE,  8'hA5, 1'b0, 1'b0, 18'h00400};
    vecs[1] = '{PAD_WRITE,  8'h3C, 1'b1, 1'b0, 18'h00000};
    vecs[2] = '{PAD_STATUS, 8'h00, 1'b0, 1'b0, 18'h00402};
    vecs[3] = '{PAD_IDLE,   8'h77, 1'b0, 1'b1, 18'h00000};
    vecs[4] = '{PAD_READ,   8'h00, 1'b0, 1'b0, 18'h00000};
    vecs[5] = '{PAD_STATUS, 8'h00, 1'b0, 1'b0, 18'h02402};
    vecs[6] = '{PAD_STATUS, 8'h00, 1'b0, 1'b1, 18'h00002};

    reset_i = 1'b1;
    doReset();

    // Directed table: writes, status, idle strobe, empty read, sticky clear.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].data, vecs[i].last, vecs[i].clear, 1'b0);
      checkOutput($sformatf("vec%0d", i), 32'(mux_o), 32'(vecs[i].exp_mux));
    end
    drained.delete();
    drainTx(3);
    checkOutput("tx_first", 32'(drained.size() > 0 ? drained[0] : 9'h0), 32'h0A5);
    checkOutput("tx_second", 32'(drained.size() > 1 ? drained[1] : 9'h0), 32'h13C);

    // Fill tx with the core stalled; the 17th byte must be dropped.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(PAD_WRITE, 8'(i + 1), 1'b0, 1'b0, 1'b0);
      if (i == 14) checkOutput("tx_full_15", 32'(mux_o[11]), 32'h0);
      if (i == 15) checkOutput("tx_full_16", 32'(mux_o[11]), 32'h1);
    end
    setMode(PAD_STATUS);
    checkOutput("tx_count_16", 32'(mux_o[5:0]), 32'd16);
    checkOutput("ovf_set", 32'(mux_o[12]), 32'h1);

    // Core pushes two bytes, pad reads them out, then under-reads.
    pushRx(8'h11, 1'b0);
    pushRx(8'h22, 1'b1);
    setMode(PAD_READ);
    checkOutput("rx_head_11", 32'(mux_o[9:0]), 32'h211);
    applyStimulus(PAD_READ, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rx_head_22", 32'(mux_o[9:0]), 32'h322);
    applyStimulus(PAD_READ, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rx_empty", 32'(mux_o[9]), 32'h0);
    applyStimulus(PAD_READ, 8'h00, 1'b0, 1'b0, 1'b0);
    setMode(PAD_STATUS);
    checkOutput("both_sticky", 32'(mux_o[13:12]), 32'h3);
    applyStimulus(PAD_STATUS, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("sticky_clear", 32'(mux_o[13:12]), 32'h0);

    // Idle strobe must not ack or move data.
    applyStimulus(PAD_IDLE, 8'h99, 1'b1, 1'b0, 1'b0);
    setMode(PAD_STATUS);

    // Push into full tx while the core pops on the same edge.
    drained.delete();
    applyStimulus(PAD_WRITE, 8'hC7, 1'b1, 1'b0, 1'b1);
    setMode(PAD_STATUS);
    checkOutput("full_pushpop_cnt", 32'(mux_o[5:0]), 32'd16);
    checkOutput("full_pushpop_ovf", 32'(mux_o[12]), 32'h0);
    drainTx(17);
    checkOutput("pushpop_tail", 32'(drained[drained.size()-1]), 32'h1C7);

    // Rx stall while full: the held byte is accepted only after a pad pop.
    for (int i = 0; i < 16; i++) pushRx(8'(8'h40 + i), 1'b0);
    pushRx(8'hEE, 1'b1);
    applyStimulus(PAD_READ, 8'h00, 1'b0, 1'b0, 1'b0);
    pushRx(8'hEE, 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(PAD_READ, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rx_stalled_byte", 32'(mux_o[9:0]), 32'h3EE);

    // Reset with bytes in flight.
    for (int i = 0; i < 5; i++) applyStimulus(PAD_WRITE, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    doReset();
    setMode(PAD_STATUS);
    checkOutput("after_reset_status", 32'(mux_o), 32'h0);

    // Randomized traffic against the queue model.
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 3))
        0: applyStimulus(pad_mode_e'(2'($urandom_range(0, 3))), 8'($urandom),
                         1'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);
        1: drainTx(int'($urandom_range(1, 4)));
        2: pushRx(8'($urandom), 1'($urandom));
        default: setMode(pad_mode_e'(2'($urandom_range(0, 3))));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/zigbee_pad_bridge.md
ZIGBEE_PAD_BRIDGE -- requirements
Module: zigbee_pad_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 16: entries per FIFO, power of two, 4..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: pad-input synchronizer depth.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 Port clk_i, input, 1: sole clock.
REQ-005 Port reset_i, input, 1: synchronous active-high reset.
REQ-006 Port sel_i, input, 2: pad mode. 00 IDLE, 01 WRITE, 10 READ, 11 STATUS.
REQ-007 Port mux_i, input, 22: pad input bus. [7:0] data, [8] last, [9] clear-sticky, [10] strobe toggle; [21:11] reserved and ignored.
REQ-008 Port mux_o, output, 18: registered pad output bus; field map per REQ-016..019.
REQ-009 Port tx_data_o/tx_last_o/tx_valid_o, output, 8/1/1: core-bound byte stream.
REQ-010 Port tx_ready_i, input, 1: core accepts tx byte when tx_valid_o and tx_ready_i are both high.
REQ-011 Port rx_data_i/rx_last_i/rx_valid_i, input, 8/1/1: pad-bound byte stream from core.
REQ-012 Port rx_ready_o, output, 1: high when the rx FIFO is not full.

Function
REQ-013 sel_i and mux_i SHALL pass through SYNC_STAGES flops; strobe event = synchronized mux_i[10] differs from its previous synchronized value.
REQ-014 A strobe event SHALL act on the synchronized mode. WRITE: push {last,data} to tx FIFO. READ: pop rx FIFO. STATUS: clear stickies if mux_i[9]=1. IDLE: ignored, no ack.
REQ-015 mux_o[10] (ack) SHALL toggle on the same edge the strobe event acts, in modes 01/10/11 only.
REQ-016 IDLE: mux_o SHALL be all zeros.
REQ-017 WRITE: mux_o[11] = tx full, mux_o[10] = ack, all other bits 0.
REQ-018 READ: mux_o[7:0] = rx head data, [8] = head last, [9] = rx not empty, [10] = ack, [17:11] = 0.
REQ-019 STATUS: mux_o[5:0] = tx count, [11:6] = rx count, [12] = overflow sticky, [13] = underflow sticky, [10] overlaid by ack, [17:14] = 0.
REQ-020 Pad-side latency: a new mux_i[10] value sampled at edge k SHALL produce the ack change on mux_o at edge k+SYNC_STAGES+1.
REQ-021 WRITE strobe with tx FIFO full and no simultaneous core pop: byte dropped, overflow sticky set, ack still toggles.
REQ-022 READ strobe with rx FIFO empty: no pop, underflow sticky set, ack still toggles.
REQ-023 Simultaneous push and pop on a full FIFO SHALL succeed with count unchanged; a push to an empty FIFO SHALL not be popped in the same cycle.
REQ-024 tx_valid_o = tx FIFO not empty; tx_data_o/tx_last_o = head entry; pop on tx_valid_o and tx_ready_i.
REQ-025 rx FIFO push on rx_valid_i and rx_ready_o; rx_valid_i while full is stalled, not dropped.
REQ-026 Counts SHALL range 0..DEPTH with no wrap; pointers SHALL wrap modulo DEPTH.
REQ-027 A mode change between strobes SHALL not alter FIFO contents; a clear and a set of the same sticky in one cycle SHALL leave it set.

Reset
REQ-028 reset_i SHALL empty both FIFOs and clear stickies, ack, sync flops and the previous-strobe flop.
REQ-029 During reset and the first cycle after it, mux_o, tx_valid_o and rx_ready_o SHALL be 0.
REQ-030 Reset asserted mid-transfer SHALL discard in-flight bytes; no strobe event SHALL be detected on the first post-reset cycle.

Structure
REQ-031 Package zigbee_pad_pkg SHALL hold the mode enum (PAD_IDLE, PAD_WRITE, PAD_READ, PAD_STATUS), mux_i/mux_o bit-position constants, and the default DEPTH.
REQ-032 Sub-module zigbee_pad_fifo (9-bit, DEPTH entries, push/pop/full/empty/count) SHALL be instantiated twice, for tx and rx.

Verification
REQ-033 WRITE: toggle strobe with bytes 0xA5, then 0x3C with last=1 -> ack toggles 3 edges after each; tx stream gives 0xA5, then 0x3C with tx_last_o=1.
REQ-034 Hold tx_ready_i=0; write 17 bytes -> mux_o[11]=1 after the 16th; 17th dropped; STATUS shows tx count 16 and overflow=1.
REQ-035 Core pushes 0x11,0x22 -> READ shows mux_o[7:0]=0x11, [9]=1; strobe -> 0x22; strobe -> [9]=0; third strobe -> underflow=1.
REQ-036 STATUS strobe with mux_i[9]=1 -> both stickies clear; strobe in IDLE -> ack unchanged, FIFOs unchanged.
REQ-037 Assert reset_i with tx count 5 -> next cycle tx_valid_o=0, mux_o=0, counts 0.
